tdm_demux_n_ch: RTL and testbench

Time-division demultiplexer: the receive end of the mux path. One W-bit serial slot stream arrives on DIN with a frame SYNC marking slot 0. The block steers each slot word into its channel position and presents the completed frame on a parallel OUT bus with a one-cycle OUT_VALID strobe. It also detects frame misalignment and reports it on a sticky flag.

---
 rtl/tdm_pkg.sv | 27 ++
 rtl/tdm_slot_counter.sv | 45 ++++
 rtl/tdm_demux_n_ch.sv | 115 +++++++++++
 tb/tb_tdm_demux_n_ch.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tdm_pkg : shared FSM encoding and sizing helpers for the TDM demux |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package tdm_pkg;

    localparam logic [0:0] ST_HUNT  = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;
    localparam int         N_CH_MIN = 2;

    // Width needed to hold 0..n-1, never below one bit.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    function automatic bit n_ch_ok(input int n);
        return n >= N_CH_MIN;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tdm_slot_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tdm_slot_counter : modulo-N_CH slot counter, load-1 / clear / tc   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tdm_slot_counter #(
    parameter int N_CH = 2,
    parameter int SW   = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc_i,
    input  logic          load1_i,
    input  logic          clr_i,
    output logic [SW-1:0] slot_o,
    output logic          tc_o
);

    logic [SW-1:0] slot_q;
    logic [SW-1:0] slot_d;

    assign tc_o   = (slot_q == SW'(N_CH - 1));
    assign slot_o = slot_q;

    always_comb begin
        slot_d = slot_q;
        if (clr_i) begin
            slot_d = '0;
        end else if (load1_i) begin
            slot_d = SW'(1);
        end else if (inc_i) begin
            slot_d = tc_o ? '0 : slot_q + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/tdm_demux_n_ch.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tdm_demux_n_ch : TDM slot stream to parallel frame, with framing   |
// |                  error detection                                   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tdm_demux_n_ch
    import tdm_pkg::*;
#(
    parameter int N_CH = 2,
    parameter int W    = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en_i,
    input  logic                    sync_i,
    input  logic [W-1:0]            din_i,
    input  logic                    err_clr_i,
    output logic [N_CH*W-1:0]       out_o,
    output logic                    out_valid_o,
    output logic [clog2(N_CH)-1:0]  slot_o,
    output logic                    frame_err_o
);

    localparam int SW = clog2(N_CH);

    if (!n_ch_ok(N_CH)) begin : g_n_ch_check
        $error("tdm_demux_n_ch: N_CH must be at least 2");
    end

    logic [0:0]               state_q, state_d;
    logic [N_CH-2:0][W-1:0]   shadow_q, shadow_d;
    logic [N_CH*W-1:0]        out_q, out_d;
    logic                     valid_q, valid_d;
    logic                     err_q, err_d;
    logic                     err_set;
    logic                     cnt_inc, cnt_load1, cnt_clr;
    logic                     slot_tc;
    logic [SW-1:0]            slot;

    tdm_slot_counter #(
        .N_CH (N_CH),
        .SW   (SW)
    ) u_slot_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (cnt_inc),
        .load1_i (cnt_load1),
        .clr_i   (cnt_clr),
        .slot_o  (slot),
        .tc_o    (slot_tc)
    );

    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        out_d     = out_q;
        valid_d   = 1'b0;
        err_set   = 1'b0;
        cnt_inc   = 1'b0;
        cnt_load1 = 1'b0;
        cnt_clr   = 1'b0;
        if (en_i) begin
            if (state_q == ST_HUNT) begin
                if (sync_i) begin
                    shadow_d[0] = din_i;
                    cnt_load1   = 1'b1;
                    state_d     = ST_RUN;
                end
            end else if (sync_i) begin
                // A sync anywhere but slot 0 restarts the frame from this word.
                err_set     = (slot != '0);
                shadow_d[0] = din_i;
                cnt_load1   = 1'b1;
            end else if (slot == '0) begin
                err_set = 1'b1;
                cnt_clr = 1'b1;
                state_d = ST_HUNT;
            end else if (slot_tc) begin
                out_d   = {din_i, shadow_q};
                valid_d = 1'b1;
                cnt_inc = 1'b1;
            end else begin
                for (int k = 0; k < N_CH - 1; k++) begin
                    if (slot == SW'(k)) shadow_d[k] = din_i;
                end
                cnt_inc = 1'b1;
            end
        end
        err_d = err_set | (err_q & ~err_clr_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_HUNT;
            shadow_q <= '0;
            out_q    <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            out_q    <= out_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    assign out_o       = out_q;
    assign out_valid_o = valid_q;
    assign slot_o      = slot;
    assign frame_err_o = err_q;

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux_n_ch.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_tdm_demux_n_ch : frame-level model check of two demux configs   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_tdm_demux_n_ch;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        sync;
    logic [3:0]  din;
    logic        clr;

    logic [1:0]  out2;
    logic        valid2;
    logic [0:0]  slot2;
    logic        err2;
    logic [15:0] out4;
    logic        valid4;
    logic [1:0]  slot4;
    logic        err4;

    int n_checks;
    int n_fail;
    bit go;

    tdm_demux_n_ch #(.N_CH(2), .W(1)) u_dut2 (
        .clk         (clk),
        .rst_n       (rst_n),
        .en_i        (en),
        .sync_i      (sync),
        .din_i       (din[0]),
        .err_clr_i   (clr),
        .out_o       (out2),
        .out_valid_o (valid2),
        .slot_o      (slot2),
        .frame_err_o (err2)
    );

    tdm_demux_n_ch #(.N_CH(4), .W(4)) u_dut4 (
        .clk         (clk),
        .rst_n       (rst_n),
        .en_i        (en),
        .sync_i      (sync),
        .din_i       (din),
        .err_clr_i   (clr),
        .out_o       (out4),
        .out_valid_o (valid4),
        .slot_o      (slot4),
        .frame_err_o (err4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: index 0 is the 2x1 instance, index 1 the 4x4 one.
    int          m_nch  [2] = '{2, 4};
    int          m_w    [2] = '{1, 4};
    bit          m_run  [2];
    int          m_slot [2];
    logic [3:0]  m_sh   [2][4];
    logic [15:0] m_out  [2];
    bit          m_valid[2];
    bit          m_err  [2];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_run[i]   = 1'b0;
            m_slot[i]  = 0;
            m_out[i]   = '0;
            m_valid[i] = 1'b0;
            m_err[i]   = 1'b0;
            for (int k = 0; k < 4; k++) m_sh[i][k] = '0;
        end
    endtask

    task automatic model_step(input int i, input bit e, input bit s,
                              input logic [3:0] d, input bit c);
        logic [3:0] dv;
        bit         new_err;
        int         n;
        n          = m_nch[i];
        dv         = d & 4'((1 << m_w[i]) - 1);
        new_err    = 1'b0;
        m_valid[i] = 1'b0;
        if (e) begin
            if (!m_run[i]) begin
                if (s) begin
                    m_sh[i][0] = dv;
                    m_slot[i]  = 1;
                    m_run[i]   = 1'b1;
                end
            end else if (s) begin
                new_err    = (m_slot[i] != 0);
                m_sh[i][0] = dv;
                m_slot[i]  = 1;
            end else if (m_slot[i] == 0) begin
                new_err  = 1'b1;
                m_run[i] = 1'b0;
            end else if (m_slot[i] == n - 1) begin
                m_out[i] = 16'(dv) << ((n - 1) * m_w[i]);
                for (int k = 0; k < n - 1; k++)
                    m_out[i] = m_out[i] | (16'(m_sh[i][k]) << (k * m_w[i]));
                m_valid[i] = 1'b1;
                m_slot[i]  = 0;
            end else begin
                m_sh[i][m_slot[i]] = dv;
                m_slot[i]          = m_slot[i] + 1;
            end
        end
        m_err[i] = new_err ? 1'b1 : (c ? 1'b0 : m_err[i]);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            for (int i = 0; i < 2; i++) model_step(i, en, sync, din, clr);
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (go) begin
            check("m2.out",   32'(out2),   32'(m_out[0]));
            check("m2.valid", 32'(valid2), 32'(m_valid[0]));
            check("m2.slot",  32'(slot2),  32'(m_slot[0]));
            check("m2.err",   32'(err2),   32'(m_err[0]));
            check("m4.out",   32'(out4),   32'(m_out[1]));
            check("m4.valid", 32'(valid4), 32'(m_valid[1]));
            check("m4.slot",  32'(slot4),  32'(m_slot[1]));
            check("m4.err",   32'(err4),   32'(m_err[1]));
        end
    end

    task automatic cyc(input bit e, input bit s, input logic [3:0] d, input bit c);
        en   = e;
        sync = s;
        din  = d;
        clr  = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst.out2",   32'(out2),   32'h0);
        check("rst.valid2", 32'(valid2), 32'h0);
        check("rst.err2",   32'(err2),   32'h0);
        check("rst.slot2",  32'(slot2),  32'h0);
        check("rst.out4",   32'(out4),   32'h0);
        check("rst.slot4",  32'(slot4),  32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        bit aligned;
        n_checks = 0;
        n_fail   = 0;
        go       = 1'b0;
        rst_n    = 1'b0;
        en       = 1'b0;
        sync     = 1'b0;
        din      = '0;
        clr      = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        go    = 1'b1;

        // Normal frames on the 2x1 instance
        cyc(1, 1, 4'h1, 0);
        cyc(1, 0, 4'h0, 0);
        check("f1.out2",   32'(out2),   32'h1);
        check("f1.valid2", 32'(valid2), 32'h1);
        cyc(1, 1, 4'h0, 0);
        check("f1.hold",   32'(out2),   32'h1);
        check("f1.pulse",  32'(valid2), 32'h0);
        cyc(1, 0, 4'h1, 0);
        check("f2.out2",   32'(out2),   32'h2);

        // Missing sync, then recovery
        cyc(1, 0, 4'h1, 0);
        check("ms.err2",   32'(err2),   32'h1);
        check("ms.slot2",  32'(slot2),  32'h0);
        check("ms.valid2", 32'(valid2), 32'h0);
        cyc(1, 1, 4'h1, 0);
        cyc(1, 0, 4'h1, 0);
        check("rc.out2",   32'(out2),   32'h3);
        check("rc.err2",   32'(err2),   32'h1);

        // Asynchronous reset mid-frame, then hunt for sync
        cyc(1, 1, 4'h1, 0);
        do_reset();
        for (int k = 0; k < 3; k++) begin
            cyc(1, 0, 4'(k + 1), 0);
            check("hunt.valid2", 32'(valid2), 32'h0);
            check("hunt.slot4",  32'(slot4),  32'h0);
        end

        // Early sync on the 4x4 instance
        cyc(1, 1, 4'h1, 0);
        cyc(1, 0, 4'h2, 0);
        check("es.slot4",  32'(slot4), 32'h2);
        cyc(1, 1, 4'h5, 0);
        check("es.err4",   32'(err4),  32'h1);
        check("es.slot4b", 32'(slot4), 32'h1);
        cyc(1, 0, 4'h6, 0);
        cyc(1, 0, 4'h7, 0);
        cyc(1, 0, 4'h8, 0);
        check("es.out4",   32'(out4),   32'h8765);
        check("es.valid4", 32'(valid4), 32'h1);

        // EN gaps on the 2x1 instance
        do_reset();
        cyc(1, 1, 4'h1, 0);
        cyc(0, 1, 4'hF, 0);
        check("gap.slot2a", 32'(slot2),  32'h1);
        cyc(0, 0, 4'hF, 0);
        check("gap.slot2b", 32'(slot2),  32'h1);
        check("gap.valid2", 32'(valid2), 32'h0);
        cyc(1, 0, 4'h0, 0);
        check("gap.out2",   32'(out2),   32'h1);
        check("gap.pulse",  32'(valid2), 32'h1);

        // Error clear, alone and colliding with a new error
        cyc(1, 0, 4'h0, 0);
        check("ec.set",    32'(err2), 32'h1);
        cyc(0, 0, 4'h0, 1);
        check("ec.clear",  32'(err2), 32'h0);
        cyc(1, 1, 4'h1, 0);
        cyc(1, 0, 4'h0, 0);
        cyc(1, 0, 4'h0, 1);
        check("ec.collide", 32'(err2), 32'h1);

        // Randomised traffic, mostly well-framed for one instance per phase
        do_reset();
        for (int t = 0; t < 3000; t++) begin
            aligned = (t < 1500) ? (m_slot[1] == 0) : (m_slot[0] == 0);
            if ($urandom_range(0, 19) == 0) aligned = ~aligned;
            cyc($urandom_range(0, 3) != 0, aligned, 4'($urandom),
                $urandom_range(0, 15) == 0);
            if (t == 2200) do_reset();
        end

        go = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
